mult_div_seq: RTL and testbench

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

---
 rtl/mult_div_seq_pkg.sv | 6 +
 rtl/mult_div_seq.sv | 94 +++++++++
 tb/tb_mult_div_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_seq_pkg.sv
// mult_div_seq_pkg: shared op encodings and FSM state type for the sequential multiplier/divider
package mult_div_seq_pkg;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/mult_div_seq.sv
// mult_div_seq: iterative shift-add multiplier and restoring divider with sign fix-up
module mult_div_seq
  import mult_div_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_OPS = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic op_q, sa, sb, neg_a, neg_b, d_ge;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, qr, bm, a_mag, b_mag, n_acc, n_qr, quo_f, rem_f;
  logic [WIDTH:0] msum, dsh, ddiff;
  logic [2*WIDTH-1:0] prod_f;
  // operand magnitudes and one iteration step; acc is product-high / remainder, qr is multiplier / quotient
  always_comb begin
    neg_a  = SIGNED_OPS && op_a[WIDTH-1];
    neg_b  = SIGNED_OPS && op_b[WIDTH-1];
    a_mag  = neg_a ? -op_a : op_a;
    b_mag  = neg_b ? -op_b : op_b;
    msum   = {1'b0, acc} + {1'b0, qr[0] ? bm : '0};
    dsh    = {acc, qr[WIDTH-1]};
    ddiff  = dsh - {1'b0, bm};
    d_ge   = dsh >= {1'b0, bm};
    n_acc  = op_q == OP_MULT ? msum[WIDTH:1] : d_ge ? ddiff[WIDTH-1:0] : dsh[WIDTH-1:0];
    n_qr   = op_q == OP_MULT ? {msum[0], qr[WIDTH-1:1]} : {qr[WIDTH-2:0], d_ge};
    prod_f = (sa ^ sb) ? -{acc, qr} : {acc, qr};
    quo_f  = (sa ^ sb) ? -qr : qr;
    rem_f  = sa ? -acc : acc;
  end
  // control FSM with registered status outputs and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      qr       <= '0;
      bm       <= '0;
      op_q     <= OP_MULT;
      sa       <= 1'b0;
      sb       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q     <= op;
          sa       <= neg_a;
          sb       <= neg_b;
          acc      <= '0;
          qr       <= a_mag;
          bm       <= b_mag;
          cnt      <= CW'(WIDTH);
          div_zero <= op == OP_DIV && op_b == '0;
          done     <= op == OP_DIV && op_b == '0;
          busy     <= !(op == OP_DIV && op_b == '0);
          state    <= (op == OP_DIV && op_b == '0) ? DONE : RUN;
        end
        RUN: begin
          acc   <= n_acc;
          qr    <= n_qr;
          cnt   <= cnt - 1'b1;
          state <= cnt == CW'(1) ? FIX : RUN;
        end
        FIX: begin
          hi    <= op_q == OP_MULT ? prod_f[2*WIDTH-1:WIDTH] : rem_f;
          lo    <= op_q == OP_MULT ? prod_f[WIDTH-1:0] : quo_f;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed checks of the sequential multiplier/divider in 32-bit signed and 8-bit unsigned builds
module tb_mult_div_seq;
  logic clock, reset;
  logic start32, op32, busy32, done32, dz32;
  logic [31:0] a32, b32, hi32, lo32;
  logic start8, op8, busy8, done8, dz8;
  logic [7:0] a8, b8, hi8, lo8;
  int compared = 0;
  int mismatched = 0;

  mult_div_seq #(.WIDTH(32), .SIGNED_OPS(1)) u32 (
    .clock(clock), .reset(reset), .start(start32), .op(op32), .op_a(a32), .op_b(b32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32));

  mult_div_seq #(.WIDTH(8), .SIGNED_OPS(0)) u8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8), .op_a(a8), .op_b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic run(input bit n, input bit o, input logic [31:0] a, input logic [31:0] b,
                     output int cyc, output bit busy1);
    if (n) begin start8 = 1; op8 = o; a8 = a[7:0]; b8 = b[7:0]; end
    else begin start32 = 1; op32 = o; a32 = a; b32 = b; end
    @(negedge clock);
    start8 = 0; start32 = 0; a32 = 32'hDEADBEEF; b32 = 0; a8 = 8'h5A; b8 = 0;
    cyc = 1;
    busy1 = n ? busy8 : busy32;
    while (!(n ? done8 : done32) && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (3) @(negedge clock);
    compared += 5;
    if (busy32 !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %0b want 0", busy32); end
    if (done32 !== 1'b0) begin mismatched++; $display("FAIL reset_done got %0b want 0", done32); end
    if (dz32 !== 1'b0) begin mismatched++; $display("FAIL reset_dz got %0b want 0", dz32); end
    if (hi32 !== 32'h0) begin mismatched++; $display("FAIL reset_hi got %h want 0", hi32); end
    if (lo32 !== 32'h0) begin mismatched++; $display("FAIL reset_lo got %h want 0", lo32); end
    reset = 0;
  endtask

  task automatic test_mult;
    int cyc; bit b1;
    run(0, 0, 32'd7, 32'hFFFFFFFD, cyc, b1);
    compared += 5;
    if (cyc !== 34) begin mismatched++; $display("FAIL mult_latency got %0d want 34", cyc); end
    if (b1 !== 1'b1) begin mismatched++; $display("FAIL mult_busy got %0b want 1", b1); end
    if (busy32 !== 1'b0) begin mismatched++; $display("FAIL mult_busy_at_done got %0b want 0", busy32); end
    if (hi32 !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL mult_7x-3_hi got %h want ffffffff", hi32); end
    if (lo32 !== 32'hFFFFFFEB) begin mismatched++; $display("FAIL mult_7x-3_lo got %h want ffffffeb", lo32); end
    @(negedge clock);
    compared++;
    if (done32 !== 1'b0) begin mismatched++; $display("FAIL done_width got %0b want 0", done32); end
    repeat (3) @(negedge clock);
    compared++;
    if (lo32 !== 32'hFFFFFFEB) begin mismatched++; $display("FAIL idle_hold_lo got %h want ffffffeb", lo32); end
    run(0, 0, 32'h12345678, 32'h10, cyc, b1);
    compared += 2;
    if (hi32 !== 32'h1) begin mismatched++; $display("FAIL mult_big_hi got %h want 1", hi32); end
    if (lo32 !== 32'h23456780) begin mismatched++; $display("FAIL mult_big_lo got %h want 23456780", lo32); end
    @(negedge clock);
    run(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, b1);
    compared += 2;
    if (hi32 !== 32'h0) begin mismatched++; $display("FAIL mult_neg_neg_hi got %h want 0", hi32); end
    if (lo32 !== 32'h1) begin mismatched++; $display("FAIL mult_neg_neg_lo got %h want 1", lo32); end
    @(negedge clock);
  endtask

  task automatic test_div;
    int cyc; bit b1;
    run(0, 1, 32'hFFFFFFF9, 32'd2, cyc, b1);
    compared += 4;
    if (cyc !== 34) begin mismatched++; $display("FAIL div_latency got %0d want 34", cyc); end
    if (lo32 !== 32'hFFFFFFFD) begin mismatched++; $display("FAIL div_-7/2_lo got %h want fffffffd", lo32); end
    if (hi32 !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL div_-7/2_hi got %h want ffffffff", hi32); end
    if (dz32 !== 1'b0) begin mismatched++; $display("FAIL div_-7/2_dz got %0b want 0", dz32); end
    @(negedge clock);
    run(0, 1, 32'd7, 32'hFFFFFFFE, cyc, b1);
    compared += 2;
    if (lo32 !== 32'hFFFFFFFD) begin mismatched++; $display("FAIL div_7/-2_lo got %h want fffffffd", lo32); end
    if (hi32 !== 32'h1) begin mismatched++; $display("FAIL div_7/-2_hi got %h want 1", hi32); end
    @(negedge clock);
    run(0, 1, 32'd100, 32'd7, cyc, b1);
    compared += 2;
    if (lo32 !== 32'd14) begin mismatched++; $display("FAIL div_100/7_lo got %h want e", lo32); end
    if (hi32 !== 32'd2) begin mismatched++; $display("FAIL div_100/7_hi got %h want 2", hi32); end
    @(negedge clock);
  endtask

  task automatic test_div_zero;
    int cyc; bit b1;
    run(0, 1, 32'd100, 32'd0, cyc, b1);
    compared += 4;
    if (cyc !== 1) begin mismatched++; $display("FAIL dz_latency got %0d want 1", cyc); end
    if (dz32 !== 1'b1) begin mismatched++; $display("FAIL dz_flag got %0b want 1", dz32); end
    if (lo32 !== 32'd14) begin mismatched++; $display("FAIL dz_keep_lo got %h want e", lo32); end
    if (hi32 !== 32'd2) begin mismatched++; $display("FAIL dz_keep_hi got %h want 2", hi32); end
    repeat (3) @(negedge clock);
    compared++;
    if (dz32 !== 1'b1) begin mismatched++; $display("FAIL dz_hold got %0b want 1", dz32); end
  endtask

  task automatic test_overflow;
    int cyc; bit b1;
    run(0, 1, 32'h80000000, 32'hFFFFFFFF, cyc, b1);
    compared += 3;
    if (lo32 !== 32'h80000000) begin mismatched++; $display("FAIL ovf_lo got %h want 80000000", lo32); end
    if (hi32 !== 32'h0) begin mismatched++; $display("FAIL ovf_hi got %h want 0", hi32); end
    if (dz32 !== 1'b0) begin mismatched++; $display("FAIL ovf_dz got %0b want 0", dz32); end
    @(negedge clock);
  endtask

  task automatic test_reset_abort;
    int cyc; bit b1;
    start32 = 1; op32 = 0; a32 = 32'd1000; b32 = 32'd1000;
    @(negedge clock);
    start32 = 0;
    repeat (10) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    compared += 4;
    if (busy32 !== 1'b0) begin mismatched++; $display("FAIL abort_busy got %0b want 0", busy32); end
    if (done32 !== 1'b0) begin mismatched++; $display("FAIL abort_done got %0b want 0", done32); end
    if (hi32 !== 32'h0) begin mismatched++; $display("FAIL abort_hi got %h want 0", hi32); end
    if (lo32 !== 32'h0) begin mismatched++; $display("FAIL abort_lo got %h want 0", lo32); end
    run(0, 0, 32'd5, 32'd5, cyc, b1);
    compared += 3;
    if (cyc !== 34) begin mismatched++; $display("FAIL post_reset_latency got %0d want 34", cyc); end
    if (lo32 !== 32'd25) begin mismatched++; $display("FAIL post_reset_lo got %h want 19", lo32); end
    if (hi32 !== 32'h0) begin mismatched++; $display("FAIL post_reset_hi got %h want 0", hi32); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int cyc; bit b1;
    run(0, 0, 32'd3, 32'd4, cyc, b1);
    compared++;
    if (lo32 !== 32'd12) begin mismatched++; $display("FAIL b2b_first_lo got %h want c", lo32); end
    @(negedge clock);
    run(0, 0, 32'd6, 32'd7, cyc, b1);
    compared += 2;
    if (cyc !== 34) begin mismatched++; $display("FAIL b2b_latency got %0d want 34", cyc); end
    if (lo32 !== 32'd42) begin mismatched++; $display("FAIL b2b_second_lo got %h want 2a", lo32); end
    @(negedge clock);
  endtask

  task automatic test_unsigned8;
    int cyc; bit b1;
    start8 = 1; op8 = 0; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clock);
    start8 = 0; a8 = 8'h11; b8 = 8'h22;
    cyc = 1;
    while (!done8 && cyc < 100) begin
      start8 = (cyc == 3);
      op8 = (cyc == 3);
      b8 = 8'h00;
      @(negedge clock);
      cyc++;
    end
    start8 = 0;
    compared += 3;
    if (cyc !== 10) begin mismatched++; $display("FAIL u8_latency got %0d want 10", cyc); end
    if (hi8 !== 8'hFE) begin mismatched++; $display("FAIL u8_mult_hi got %h want fe", hi8); end
    if (lo8 !== 8'h01) begin mismatched++; $display("FAIL u8_mult_lo got %h want 01", lo8); end
    @(negedge clock);
    compared++;
    if (dz8 !== 1'b0) begin mismatched++; $display("FAIL u8_ignored_start_dz got %0b want 0", dz8); end
    run(1, 1, 32'd200, 32'd7, cyc, b1);
    compared += 2;
    if (lo8 !== 8'd28) begin mismatched++; $display("FAIL u8_div_lo got %h want 1c", lo8); end
    if (hi8 !== 8'd4) begin mismatched++; $display("FAIL u8_div_hi got %h want 04", hi8); end
    @(negedge clock);
  endtask

  initial begin
    reset = 1; start32 = 0; op32 = 0; a32 = 0; b32 = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0;
    @(negedge clock);
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_overflow;
    test_reset_abort;
    test_back_to_back;
    test_unsigned8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
